// File: rtl/ni_local_tx_pkg.sv
// Shared types and defaults for the local-port packet injector.
package ni_local_tx_pkg;

    // Default flit width of the mesh; METADEFLIT is half of this.
    localparam int TAM_FLIT_DEFAULT = 16;

    // Injector sequencing: one state per flit kind, PAYLOAD loops per word.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_SIZE    = 3'd2,
        S_SRC     = 3'd3,
        S_PAYLOAD = 3'd4
    } tx_state_t;

endpackage

// File: rtl/ni_local_tx_fifo.sv
// Synchronous payload FIFO; pointers carry one wrap bit to tell full from empty.
module ni_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer update; push and pop in one cycle leave occupancy unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ni_local_tx.sv
// Local-port packet injector: command + payload FIFO serialized into
// header / size / source / payload flits under the mesh credit protocol.
module ni_local_tx
    import ni_local_tx_pkg::*;
#(
    parameter int                          TAM_FLIT   = TAM_FLIT_DEFAULT,
    parameter logic [TAM_FLIT-1:0]         ADDRESS    = '0,
    parameter int                          FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [TAM_FLIT-1:0] cmd_target,
    input  logic [TAM_FLIT-2:0] cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [TAM_FLIT-1:0] wr_data,
    output logic                tx,
    output logic [TAM_FLIT-1:0] data_out,
    input  logic                credit_i,
    output logic                busy,
    output logic                pkt_sent
);
    localparam int METADEFLIT = TAM_FLIT / 2;
    localparam int LW         = TAM_FLIT - 1;

    // Source flit is the node address laid out as {X, Y}.
    localparam logic [TAM_FLIT-1:0] SRC_FLIT =
        {ADDRESS[TAM_FLIT-1:METADEFLIT], ADDRESS[METADEFLIT-1:0]};

    tx_state_t         state;
    logic [TAM_FLIT-1:0] target;
    logic [LW-1:0]     len;
    logic [LW-1:0]     remaining;
    logic              last_in_reg;  // output register holds the final flit of a packet

    logic              load_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [TAM_FLIT-1:0] fifo_rdata;

    assign load_ok   = !tx || credit_i;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wr_ready  = !fifo_full;
    assign fifo_pop  = (state == S_PAYLOAD) && load_ok && !fifo_empty;

    ni_fifo #(
        .WIDTH (TAM_FLIT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_valid && !fifo_full),
        .wdata (wr_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer and output flit register; state advances when its flit is loaded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            target      <= '0;
            len         <= '0;
            remaining   <= '0;
            tx          <= 1'b0;
            data_out    <= '0;
            last_in_reg <= 1'b0;
            pkt_sent    <= 1'b0;
        end else begin
            pkt_sent <= tx && credit_i && last_in_reg;
            case (state)
                S_IDLE: begin
                    if (load_ok) begin
                        tx          <= 1'b0;
                        last_in_reg <= 1'b0;
                    end
                    if (cmd_valid) begin
                        target    <= cmd_target;
                        len       <= cmd_len;
                        remaining <= cmd_len;
                        state     <= S_HEADER;
                    end
                end
                S_HEADER: if (load_ok) begin
                    tx          <= 1'b1;
                    data_out    <= target;
                    last_in_reg <= 1'b0;
                    state       <= S_SIZE;
                end
                S_SIZE: if (load_ok) begin
                    tx          <= 1'b1;
                    data_out    <= TAM_FLIT'(len) + TAM_FLIT'(1);
                    last_in_reg <= 1'b0;
                    state       <= S_SRC;
                end
                S_SRC: if (load_ok) begin
                    tx          <= 1'b1;
                    data_out    <= SRC_FLIT;
                    last_in_reg <= (len == '0);
                    state       <= (len == '0) ? S_IDLE : S_PAYLOAD;
                end
                S_PAYLOAD: if (load_ok) begin
                    if (!fifo_empty) begin
                        tx          <= 1'b1;
                        data_out    <= fifo_rdata;
                        remaining   <= remaining - LW'(1);
                        last_in_reg <= (remaining == LW'(1));
                        if (remaining == LW'(1)) state <= S_IDLE;
                    end else begin
                        // Payload not yet written: bubble until a word arrives.
                        tx          <= 1'b0;
                        last_in_reg <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_local_tx.sv
// Directed, table-driven bench for ni_local_tx: each row drives inputs for
// one clock and lists the outputs expected just after that edge.
module tb_ni_local_tx;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_target;
    logic [14:0] cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        tx;
    logic [15:0] data_out;
    logic        credit_i;
    logic        busy;
    logic        pkt_sent;

    ni_local_tx #(
        .TAM_FLIT   (16),
        .ADDRESS    (16'h0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_len    (cmd_len),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .tx         (tx),
        .data_out   (data_out),
        .credit_i   (credit_i),
        .busy       (busy),
        .pkt_sent   (pkt_sent)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        cv;
        logic [15:0] tgt;
        logic [14:0] len;
        logic        wv;
        logic [15:0] wd;
        logic        cr;
        logic        e_tx;
        logic [15:0] e_data;
        logic        e_pkt;
        logic        e_crdy;
        logic        e_wrdy;
    } vec_t;

    vec_t vecs[$];
    int   next_row = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic cv, input logic [15:0] tgt, input logic [14:0] len,
                       input logic wv, input logic [15:0] wd, input logic cr,
                       input logic e_tx, input logic [15:0] e_data, input logic e_pkt,
                       input logic e_crdy, input logic e_wrdy);
        vec_t v;
        v.cv = cv; v.tgt = tgt; v.len = len; v.wv = wv; v.wd = wd; v.cr = cr;
        v.e_tx = e_tx; v.e_data = e_data; v.e_pkt = e_pkt; v.e_crdy = e_crdy; v.e_wrdy = e_wrdy;
        vecs.push_back(v);
    endtask

    // Apply every row queued since the last call, one clock per row.
    task automatic run_pending();
        for (int i = next_row; i < vecs.size(); i++) begin
            cmd_valid  = vecs[i].cv;
            cmd_target = vecs[i].tgt;
            cmd_len    = vecs[i].len;
            wr_valid   = vecs[i].wv;
            wr_data    = vecs[i].wd;
            credit_i   = vecs[i].cr;
            @(posedge clock);
            #1;
            chk($sformatf("row%0d_tx", i), 32'(tx), 32'(vecs[i].e_tx));
            if (vecs[i].e_tx)
                chk($sformatf("row%0d_data", i), 32'(data_out), 32'(vecs[i].e_data));
            chk($sformatf("row%0d_pkt_sent", i), 32'(pkt_sent), 32'(vecs[i].e_pkt));
            chk($sformatf("row%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_crdy));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(!vecs[i].e_crdy));
            chk($sformatf("row%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wrdy));
        end
        next_row = vecs.size();
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, "_tx"},        32'(tx),        32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_wr_ready"},  32'(wr_ready),  32'd1);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_pkt_sent"},  32'(pkt_sent),  32'd0);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_target = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; credit_i = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle_reset("reset");
        chk("reset_data_out", 32'(data_out), 32'd0);

        // Basic packet, payload prefilled, credit always high.
        add(0, 16'h0,    0, 1, 16'h00A1, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00A2, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00A3, 1,  0, 16'h0,    0, 1, 1);
        add(1, 16'h0102, 3, 0, 16'h0,    1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0102, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0004, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0000, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00A1, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00A2, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00A3, 0, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    1, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    0, 1, 1);

        // Same packet, credit withheld for three cycles while SIZE is presented.
        add(0, 16'h0,    0, 1, 16'h00A1, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00A2, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00A3, 1,  0, 16'h0,    0, 1, 1);
        add(1, 16'h0102, 3, 0, 16'h0,    1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0102, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0004, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    0,  1, 16'h0004, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    0,  1, 16'h0004, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    0,  1, 16'h0004, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0000, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00A1, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00A2, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00A3, 0, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    1, 1, 1);

        // Zero-length packet: header, size 1, source, done.
        add(1, 16'h0201, 0, 0, 16'h0,    1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0201, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0001, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0000, 0, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    1, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    0, 1, 1);

        // Payload arrives late: bubble after the source flit, then B1, B2.
        add(1, 16'h0303, 2, 0, 16'h0,    1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0303, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0003, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0000, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 1, 16'h00B1, 1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 1, 16'h00B2, 1,  1, 16'h00B1, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00B2, 0, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    1, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    0, 1, 1);

        // FIFO full: wr_ready drops, push refused while full, push+pop keeps level.
        add(0, 16'h0,    0, 1, 16'h00C1, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00C2, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00C3, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00C4, 1,  0, 16'h0,    0, 1, 0);
        add(1, 16'h0404, 5, 1, 16'h00C5, 1,  0, 16'h0,    0, 0, 0);
        add(0, 16'h0,    0, 1, 16'h00C5, 1,  1, 16'h0404, 0, 0, 0);
        add(0, 16'h0,    0, 1, 16'h00C5, 1,  1, 16'h0006, 0, 0, 0);
        add(0, 16'h0,    0, 1, 16'h00C5, 1,  1, 16'h0000, 0, 0, 0);
        add(0, 16'h0,    0, 1, 16'h00C5, 1,  1, 16'h00C1, 0, 0, 1);
        add(0, 16'h0,    0, 1, 16'h00C5, 1,  1, 16'h00C2, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00C3, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00C4, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00C5, 0, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    1, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    0, 1, 1);

        // Lead-in to a mid-payload reset: four words buffered, packet of two.
        add(0, 16'h0,    0, 1, 16'h00D1, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00D2, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00D3, 1,  0, 16'h0,    0, 1, 1);
        add(0, 16'h0,    0, 1, 16'h00D4, 1,  0, 16'h0,    0, 1, 0);
        add(1, 16'h0505, 2, 0, 16'h0,    1,  0, 16'h0,    0, 0, 0);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0505, 0, 0, 0);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0003, 0, 0, 0);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0000, 0, 0, 0);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00D1, 0, 0, 1);
        run_pending();

        // Asynchronous reset between edges while a payload flit is on the wire.
        #2;
        reset = 1'b1;
        #1;
        check_idle_reset("async_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle_reset("after_reset");

        // Fresh packet after reset must carry E1, not a stale D word.
        add(0, 16'h0,    0, 1, 16'h00E1, 1,  0, 16'h0,    0, 1, 1);
        add(1, 16'h0606, 1, 0, 16'h0,    1,  0, 16'h0,    0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0606, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0002, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h0000, 0, 0, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  1, 16'h00E1, 0, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    1, 1, 1);
        add(0, 16'h0,    0, 0, 16'h0,    1,  0, 16'h0,    0, 1, 1);
        run_pending();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
